// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
// Holds default sizes, data width, out-of-range read value and port ids.
package ram_arb_pkg;

  localparam int MEM_DEPTH_DEF = 28672;
  localparam int AW_DEF        = 15;
  localparam int DW            = 8;

  localparam logic [DW-1:0] OOR_RDATA = 8'hFF;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // One in-flight read: issuing port and out-of-range flag.
  typedef struct packed {
    logic v;
    logic port;
    logic oor;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant register.
// Ports: clk, reset_n, req_i[1:0] (bit0=A, bit1=B), gnt_o[1:0] one-hot.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b11:   gnt_o = (last_q == PORT_A) ? 2'b10 : 2'b01;
      default: gnt_o = req_i;
    endcase
    if (gnt_o[1])      last_d = PORT_B;
    else if (gnt_o[0]) last_d = PORT_A;
  end

  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= PORT_B;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two-port (CPU/DMA) arbiter onto a single-port RAM with registered reads.
// Ports: A/B req/we/addr/din in, gnt/rvalid/dout/err out; ram_we/addr/din out, ram_dout in.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_dout,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_dout,
  output logic          b_err,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);

  logic [1:0]    req;
  logic [1:0]    win;
  logic          any_win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic          sel_oor;

  logic          ram_we_q,   ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q,  ram_din_d;
  logic          a_gnt_q,    a_gnt_d;
  logic          b_gnt_q,    b_gnt_d;
  logic          a_err_q,    a_err_d;
  logic          b_err_q,    b_err_d;
  logic          a_rv_q,     a_rv_d;
  logic          b_rv_q,     b_rv_d;
  logic [DW-1:0] a_dout_q,   a_dout_d;
  logic [DW-1:0] b_dout_q,   b_dout_d;
  rd_tag_t       rd1_q,      rd1_d;
  rd_tag_t       rd2_q;
  logic [DW-1:0] rd_data;

  // A port is masked while its grant is showing.
  assign req = {b_req & ~b_gnt_q, a_req & ~a_gnt_q};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req),
    .gnt_o   (win)
  );

  assign any_win  = |win;
  assign sel_we   = win[1] ? b_we   : a_we;
  assign sel_addr = win[1] ? b_addr : a_addr;
  assign sel_din  = win[1] ? b_din  : a_din;
  assign sel_oor  = {1'b0, sel_addr} >= DEPTH_W;

  // rd2 lines up with ram_dout for the read issued two cycles back.
  assign rd_data = rd2_q.oor ? OOR_RDATA : ram_dout;

  always_comb begin
    ram_we_d   = any_win & sel_we & ~sel_oor;
    ram_addr_d = any_win ? sel_addr : ram_addr_q;
    ram_din_d  = any_win ? sel_din  : ram_din_q;
    a_gnt_d    = win[0];
    b_gnt_d    = win[1];
    a_err_d    = win[0] & sel_oor;
    b_err_d    = win[1] & sel_oor;
    rd1_d.v    = any_win & ~sel_we;
    rd1_d.port = win[1];
    rd1_d.oor  = sel_oor;
    a_rv_d     = rd2_q.v & (rd2_q.port == PORT_A);
    b_rv_d     = rd2_q.v & (rd2_q.port == PORT_B);
    a_dout_d   = a_rv_d ? rd_data : a_dout_q;
    b_dout_d   = b_rv_d ? rd_data : b_dout_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rv_q     <= 1'b0;
      b_rv_q     <= 1'b0;
      a_dout_q   <= '0;
      b_dout_q   <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
    end else begin
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rv_q     <= a_rv_d;
      b_rv_q     <= b_rv_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd1_q;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_dout   = a_dout_q;
  assign b_dout   = b_dout_q;

endmodule
